// File: rtl/bus2reg_arb_pkg.sv
// Shared types and constants for the Bus2Reg round-robin arbiter.
package bus2reg_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_t;

  // Read data returned to a requester whose transfer was aborted by timeout.
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus2reg_arbiter_if.sv
// Requester-side and regmap-side signal bundle of the Bus2Reg arbiter.
//
// Handshake semantics: a requester raises req_valid[i] with its command fields
// and holds all of them stable until it sees req_ready[i] high for one cycle;
// req_err and req_rd_data are only meaningful in that cycle. On the regmap
// side the arbiter holds bus_req and the command stable until bus_ready is seen
// with bus_req high; bus_ready while bus_req is low is ignored.
interface bus2reg_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  import bus2reg_arb_pkg::*;

  localparam int GW = idx_width(NUM_REQ);

  // requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_is_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_biten;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          req_err;
  logic [DATA_WIDTH-1:0]         req_rd_data;

  // regmap side
  logic                          bus_req;
  logic                          bus_req_is_wr;
  logic [ADDR_WIDTH-1:0]         bus_addr;
  logic [DATA_WIDTH-1:0]         bus_wr_data;
  logic [DATA_WIDTH-1:0]         bus_wr_biten;
  logic                          bus_ready;
  logic [DATA_WIDTH-1:0]         bus_rd_data;
  logic                          bus_req_stall_wr;
  logic                          bus_req_stall_rd;

  // debug
  logic [GW-1:0]                 grant_id;
  arb_state_t                    dbg_state;

  // The arbiter itself.
  modport master (
    input  req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
    output req_ready, req_err, req_rd_data,
    output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    input  bus_ready, bus_rd_data, bus_req_stall_wr, bus_req_stall_rd,
    output grant_id, dbg_state
  );

  // The environment: requesters plus regmap.
  modport slave (
    output req_valid, req_is_wr, req_addr, req_wr_data, req_wr_biten,
    input  req_ready, req_err, req_rd_data,
    input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    output bus_ready, bus_rd_data, bus_req_stall_wr, bus_req_stall_rd,
    input  grant_id, dbg_state
  );

endinterface

// File: rtl/bus2reg_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, circular.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // Scan N positions starting at ptr and keep the first requester found.
  always_comb begin
    int j;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    j            = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any             = 1'b1;
        grant_idx       = IW'(j);
        grant_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus2reg_arbiter.sv
// Shares one Bus2Reg regmap port between NUM_REQ requesters, round-robin,
// with stall handling and a timeout that aborts hung transfers.
module bus2reg_arbiter
  import bus2reg_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  bus2reg_arbiter_if.master     bus
);

  localparam int GW   = idx_width(NUM_REQ);
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  arb_state_t              state_q,    state_d;
  logic [GW-1:0]           rr_ptr_q,   rr_ptr_d;
  logic [GW-1:0]           grant_q,    grant_d;
  logic [NUM_REQ-1:0]      grant_oh_q, grant_oh_d;
  logic                    is_wr_q,    is_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
  logic [DATA_WIDTH-1:0]   biten_q,    biten_d;
  logic [TW-1:0]           tcnt_q,     tcnt_d;

  logic [NUM_REQ-1:0]      arb_onehot;
  logic [GW-1:0]           arb_idx;
  logic                    arb_any;

  logic                    stalled;
  logic                    bus_req_int;
  logic                    complete;
  logic                    timed_out;

  rr_arbiter #(.N(NUM_REQ), .IW(GW)) u_rr (
    .req          (bus.req_valid),
    .ptr          (rr_ptr_q),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any          (arb_any)
  );

  // Stall gating, completion and timeout detection for the latched transfer.
  always_comb begin
    stalled     = is_wr_q ? bus.bus_req_stall_wr : bus.bus_req_stall_rd;
    bus_req_int = (state_q == ARB_ACTIVE) && !stalled;
    complete    = bus_req_int && bus.bus_ready;
    timed_out   = (TIMEOUT_CYCLES != 0) && bus_req_int && !bus.bus_ready &&
                  (tcnt_q == TW'(TLIM));
  end

  // Next-state logic: arbitrate and latch in IDLE, track the transfer in ACTIVE.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    biten_d    = biten_q;
    tcnt_d     = tcnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_any) begin
          state_d    = ARB_ACTIVE;
          grant_d    = arb_idx;
          grant_oh_d = arb_onehot;
          is_wr_d    = bus.req_is_wr[arb_idx];
          addr_d     = bus.req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = bus.req_wr_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          biten_d    = bus.req_wr_biten[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          tcnt_d     = '0;
          rr_ptr_d   = (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ARB_ACTIVE: begin
        if (complete || timed_out) begin
          state_d = ARB_IDLE;
        end else if (bus_req_int) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      biten_q    <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      biten_q    <= biten_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign bus.bus_req       = bus_req_int;
  assign bus.bus_req_is_wr = is_wr_q;
  assign bus.bus_addr      = addr_q;
  assign bus.bus_wr_data   = wdata_q;
  assign bus.bus_wr_biten  = biten_q;

  // Completion is combinational from bus_ready so a zero-wait regmap
  // finishes in the first ACTIVE cycle.
  assign bus.req_ready   = (complete || timed_out) ? grant_oh_q : '0;
  assign bus.req_err     = timed_out;
  assign bus.req_rd_data = timed_out ? DATA_WIDTH'(ERR_RDATA) : bus.bus_rd_data;

  assign bus.grant_id  = grant_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bus2reg_arbiter.sv
// Bench for bus2reg_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of requesters and regmap.
module tb_bus2reg_arbiter;
  import bus2reg_arb_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int T  = 8;

  // ---------------- clock / reset ----------------
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  bus2reg_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

  bus2reg_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .ACLK   (aclk),
    .ARESET (areset),
    .bus    (bif)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];   // expected requester id of each granted transfer
  int done_ids[$];           // requester ids in order of completion

  bit            pend[N];
  bit            cool[N];
  bit            p_wr[N];
  logic [AW-1:0] p_addr[N];
  logic [DW-1:0] p_wd[N];
  logic [DW-1:0] p_be[N];

  bit m_busy;
  int m_id;
  int m_cnt;
  int m_ptr;
  int n_breq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic post(input int i, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] be);
    pend[i]   = 1'b1;
    p_wr[i]   = wr;
    p_addr[i] = a;
    p_wd[i]   = d;
    p_be[i]   = be;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      bif.req_valid[i]               = pend[i];
      bif.req_is_wr[i]               = p_wr[i];
      bif.req_addr[i*AW +: AW]       = p_addr[i];
      bif.req_wr_data[i*DW +: DW]    = p_wd[i];
      bif.req_wr_biten[i*DW +: DW]   = p_be[i];
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, run the model.
  task automatic cycle(input bit swr, input bit srd, input bit rdy, input logic [DW-1:0] rdat);
    bit stalled;
    int win;
    int exp_id;
    logic [N-1:0] exp_rdy;
    @(negedge aclk);
    for (int i = 0; i < N; i++) cool[i] = 1'b0;
    drive_req();
    bif.bus_req_stall_wr = swr;
    bif.bus_req_stall_rd = srd;
    bif.bus_ready        = rdy;
    bif.bus_rd_data      = rdat;
    #1;
    chk("state", bif.dbg_state, m_busy ? ARB_ACTIVE : ARB_IDLE);
    if (bif.bus_req) n_breq++;
    if (!m_busy) begin
      chk("idle_bus_req", bif.bus_req, 1'b0);
      chk("idle_ready", bif.req_ready, '0);
      win = -1;
      for (int k = 0; k < N; k++)
        if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) begin
        m_busy = 1'b1;
        m_id   = win;
        m_cnt  = 0;
        m_ptr  = (win + 1) % N;
        exp_q.push_back(DW'(win));
      end
    end else begin
      chk("grant_id", bif.grant_id, m_id);
      chk("bus_addr", bif.bus_addr, p_addr[m_id]);
      chk("bus_is_wr", bif.bus_req_is_wr, p_wr[m_id]);
      chk("bus_wr_data", bif.bus_wr_data, p_wd[m_id]);
      chk("bus_wr_biten", bif.bus_wr_biten, p_be[m_id]);
      stalled = p_wr[m_id] ? swr : srd;
      chk("bus_req", bif.bus_req, !stalled);
      if (!stalled && (rdy || m_cnt == T - 1)) begin
        exp_id = int'(exp_q.pop_front());
        exp_rdy = '0;
        exp_rdy[exp_id] = 1'b1;
        chk("req_ready", bif.req_ready, exp_rdy);
        chk("req_err", bif.req_err, !rdy);
        chk("req_rd_data", bif.req_rd_data, rdy ? rdat : 32'hDEAD_BEEF);
        done_ids.push_back(exp_id);
        pend[exp_id] = 1'b0;
        cool[exp_id] = 1'b1;
        m_busy = 1'b0;
      end else begin
        chk("ready_low", bif.req_ready, '0);
        if (!stalled) m_cnt++;
      end
    end
  endtask

  // Hold reset for n cycles and check reset values; requesters abandon requests.
  task automatic do_reset(input int n);
    @(negedge aclk);
    areset = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
    bif.bus_ready = 1'b0;
    #1;
    chk("rst_entry_ready", bif.req_ready, '0);
    repeat (n) begin
      @(negedge aclk);
      #1;
      chk("rst_state", bif.dbg_state, ARB_IDLE);
      chk("rst_bus_req", bif.bus_req, 1'b0);
      chk("rst_grant_id", bif.grant_id, 0);
      chk("rst_req_ready", bif.req_ready, '0);
      chk("rst_req_err", bif.req_err, 1'b0);
      chk("rst_bus_addr", bif.bus_addr, '0);
      chk("rst_bus_wr_data", bif.bus_wr_data, '0);
      chk("rst_bus_wr_biten", bif.bus_wr_biten, '0);
      chk("rst_bus_is_wr", bif.bus_req_is_wr, 1'b0);
    end
    areset = 1'b0;
    m_busy = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) cool[i] = 1'b0;
  endtask

  // ---------------- directed steps + random traffic ----------------
  initial begin
    int b0;
    int d0;
    int issued[2];
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; cool[i] = 1'b0; p_wr[i] = 1'b0;
      p_addr[i] = '0; p_wd[i] = '0; p_be[i] = '0;
    end
    m_busy = 1'b0; m_id = 0; m_cnt = 0; m_ptr = 0; n_breq = 0;
    bif.bus_req_stall_wr = 1'b0;
    bif.bus_req_stall_rd = 1'b0;
    bif.bus_ready        = 1'b0;
    bif.bus_rd_data      = '0;
    drive_req();
    do_reset(2);

    // Single read, regmap answers in the 2nd ACTIVE cycle.
    post(0, 1'b0, 32'h10, 32'h0, 32'h0);
    b0 = n_breq;
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    chk("rd_addr", bif.bus_addr, 32'h10);
    cycle(0, 0, 1, 32'h1234_5678);
    chk("rd_ready", bif.req_ready, 3'b001);
    chk("rd_data", bif.req_rd_data, 32'h1234_5678);
    chk("rd_err", bif.req_err, 1'b0);
    cycle(0, 0, 0, 32'h0);
    chk("rd_busreq_cycles", n_breq - b0, 2);

    // Contention: requesters 0 and 1 each issue 4 transfers, zero-wait regmap.
    issued[0] = 0; issued[1] = 0;
    d0 = done_ids.size();
    repeat (16) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && !cool[i] && issued[i] < 4) begin
          post(i, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
          issued[i]++;
        end
      cycle(0, 0, 1, $urandom);
    end
    chk("fair_count", done_ids.size() - d0, 8);
    for (int k = 0; k < 8; k++)
      if (d0 + k < done_ids.size())
        chk("fair_order", done_ids[d0 + k], (k % 2 == 0) ? 1 : 0);

    // Write with stalls; bus_ready during stall is ignored, counter frozen.
    post(1, 1'b1, 32'h20, 32'hA5A5_A5A5, 32'h0000_FFFF);
    cycle(0, 0, 0, 32'h0);
    b0 = n_breq;
    repeat (5) cycle(1, 0, 1, $urandom);
    chk("wr_stall_busreq", n_breq - b0, 0);
    repeat (3) cycle(0, 1, 0, 32'h0);
    repeat (3) cycle(1, 0, 0, 32'h0);
    repeat (3) cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h0);
    chk("wr_ready", bif.req_ready, 3'b010);
    chk("wr_err", bif.req_err, 1'b0);
    chk("wr_biten", bif.bus_wr_biten, 32'h0000_FFFF);
    chk("wr_data", bif.bus_wr_data, 32'hA5A5_A5A5);
    chk("wr_busreq_cycles", n_breq - b0, 7);
    cycle(0, 0, 0, 32'h0);

    // Timeout: no bus_ready for 8 bus_req-high cycles.
    post(0, 1'b0, 32'h44, 32'h0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    b0 = n_breq;
    repeat (7) cycle(0, 0, 0, $urandom);
    cycle(0, 0, 0, 32'h5555_5555);
    chk("to_ready", bif.req_ready, 3'b001);
    chk("to_err", bif.req_err, 1'b1);
    chk("to_data", bif.req_rd_data, 32'hDEAD_BEEF);
    chk("to_busreq_cycles", n_breq - b0, 8);
    post(1, 1'b0, 32'h48, 32'h0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h0BAD_F00D);
    chk("after_to_ready", bif.req_ready, 3'b010);
    chk("after_to_err", bif.req_err, 1'b0);
    chk("after_to_data", bif.req_rd_data, 32'h0BAD_F00D);
    cycle(0, 0, 0, 32'h0);

    // bus_ready coincides with the last allowed count: normal completion.
    post(2, 1'b0, 32'h50, 32'h0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    repeat (7) cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'hCAFE_0001);
    chk("sim_ready", bif.req_ready, 3'b100);
    chk("sim_err", bif.req_err, 1'b0);
    chk("sim_data", bif.req_rd_data, 32'hCAFE_0001);
    cycle(0, 0, 0, 32'h0);

    // Reset mid-transfer: requester 0 in flight, then rr_ptr must restart at 0.
    post(0, 1'b0, 32'h60, 32'h0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    do_reset(1);
    post(1, 1'b0, 32'h64, 32'h0, 32'h0);
    post(0, 1'b0, 32'h68, 32'h0, 32'h0);
    cycle(0, 0, 0, 32'h0);
    cycle(0, 0, 1, 32'h7777_0000);
    chk("post_rst_grant", bif.grant_id, 0);
    chk("post_rst_ready", bif.req_ready, 3'b001);

    // Randomized traffic from all requesters against a random regmap.
    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && !cool[i] && $urandom_range(0, 3) == 0)
          post(i, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 5) == 0), $urandom);
    end
    repeat (40) cycle(0, 0, 1, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
